// File: rtl/demux_1_to_n_collect_if.sv
// Handshake bundle for demux_1_to_n_collect: word-side upstream signals and vector-side downstream signals.
// DEMUX_LANE_MASK_EN adds o_lane_mask to the bundle.
interface demux_1_to_n_collect_if #(
  parameter int BIT_WIDTH   = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int NUM_OUTPUTS = 16
);
  logic                             i_valid;
  logic                             o_ready;
  logic [BIT_WIDTH-1:0]             i_data;
  logic                             i_flush;
  logic                             o_valid;
  logic                             i_ready;
  logic [NUM_OUTPUTS*BIT_WIDTH-1:0] o_B;
  logic [SEL_WIDTH:0]               o_count;
`ifdef DEMUX_LANE_MASK_EN
  logic [NUM_OUTPUTS-1:0]           o_lane_mask;
`endif

  modport slave (
    input  i_valid, i_data, i_flush, i_ready,
    output o_ready, o_valid, o_B, o_count
`ifdef DEMUX_LANE_MASK_EN
    , output o_lane_mask
`endif
  );

  modport master (
    output i_valid, i_data, i_flush, i_ready,
    input  o_ready, o_valid, o_B, o_count
`ifdef DEMUX_LANE_MASK_EN
    , input o_lane_mask
`endif
  );
endinterface

// File: rtl/demux_1_to_n_collect.sv
// Serial-to-parallel lane collector: packs consecutive words into lanes and hands the vector off.
// Optional DEMUX_LANE_MASK_EN adds a per-lane written mask (o_lane_mask).
//
//   state  | meaning
//   FILL   | accepting words into lanes, o_valid low
//   FULL   | vector presented downstream, waiting for i_ready
module demux_1_to_n_collect #(
  parameter int BIT_WIDTH   = 16,
  parameter int SEL_WIDTH   = 4,
  parameter int NUM_OUTPUTS = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  demux_1_to_n_collect_if.slave bus
);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;
  localparam int VEC_W = NUM_OUTPUTS * BIT_WIDTH;
  localparam logic [SEL_WIDTH-1:0] LAST_LANE  = SEL_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [SEL_WIDTH:0]   FULL_COUNT = (SEL_WIDTH + 1)'(NUM_OUTPUTS);

  logic [0:0]           state;
  logic [SEL_WIDTH-1:0] lane_cnt;
  logic [VEC_W-1:0]     vec;
  logic [SEL_WIDTH:0]   count;
  logic                 accept;
  logic                 take;

  assign bus.o_ready = (state == S_FILL) | bus.i_ready;
  assign bus.o_valid = (state == S_FULL);
  assign bus.o_B     = vec;
  assign bus.o_count = count;
  assign accept      = bus.i_valid & bus.o_ready;
  assign take        = bus.o_valid & bus.i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FILL;
      lane_cnt <= '0;
      vec      <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) vec[lane_cnt*BIT_WIDTH +: BIT_WIDTH] <= bus.i_data;
          // Completing the last lane wins over a coincident flush.
          if (accept && (lane_cnt == LAST_LANE)) begin
            lane_cnt <= '0;
            count    <= FULL_COUNT;
            state    <= S_FULL;
          end else if (bus.i_flush && (accept || (lane_cnt != '0))) begin
            lane_cnt <= '0;
            count    <= {1'b0, lane_cnt} + {{SEL_WIDTH{1'b0}}, accept};
            state    <= S_FULL;
          end else if (accept) begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        default: begin
          if (take) begin
            if (accept) begin
              vec <= VEC_W'(bus.i_data);
              // A single-lane vector is complete the moment its word arrives.
              if (NUM_OUTPUTS == 1) begin
                count <= FULL_COUNT;
              end else begin
                lane_cnt <= SEL_WIDTH'(1);
                count    <= '0;
                state    <= S_FILL;
              end
            end else begin
              vec   <= '0;
              count <= '0;
              state <= S_FILL;
            end
          end
        end
      endcase
    end
  end

`ifdef DEMUX_LANE_MASK_EN
  logic [NUM_OUTPUTS-1:0] lane_mask;

  assign bus.o_lane_mask = lane_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_mask <= '0;
    end else if (state == S_FILL) begin
      if (accept) lane_mask <= lane_mask | (NUM_OUTPUTS'(1) << lane_cnt);
    end else if (take) begin
      lane_mask <= accept ? NUM_OUTPUTS'(1) : '0;
    end
  end
`else
  // Without the mask option no per-lane written state is kept.
`endif
endmodule

// File: tb/tb_demux_1_to_n_collect.sv
// Scoreboard bench for demux_1_to_n_collect: a 16-lane instance checked against a lane model,
// plus a 1-lane instance for the degenerate pass-through case.
module tb_demux_1_to_n_collect;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  demux_1_to_n_collect_if #(.BIT_WIDTH(16), .SEL_WIDTH(4), .NUM_OUTPUTS(16)) bus ();
  demux_1_to_n_collect_if #(.BIT_WIDTH(16), .SEL_WIDTH(4), .NUM_OUTPUTS(1))  bus1 ();

  demux_1_to_n_collect #(.BIT_WIDTH(16), .SEL_WIDTH(4), .NUM_OUTPUTS(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  demux_1_to_n_collect #(.BIT_WIDTH(16), .SEL_WIDTH(4), .NUM_OUTPUTS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic [255:0] vec;
    logic [4:0]   cnt;
  } exp_t;

  exp_t         sb[$];
  logic         m_full = 1'b0;
  int           m_cnt = 0;
  logic [255:0] m_vec = '0;

  // Lane model: sampled mid-cycle, pushes each completed vector and pops it on handoff.
  initial begin
    logic m_ready, acc, tk;
    logic [15:0] em;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        m_full = 1'b0;
        m_cnt  = 0;
        m_vec  = '0;
        sb.delete();
      end else begin
        m_ready = !m_full || bus.i_ready;
        checks += 2;
        if (bus.o_ready !== m_ready) begin
          errors++;
          $display("FAIL o_ready t=%0t got=%b exp=%b", $time, bus.o_ready, m_ready);
        end
        if (bus.o_valid !== m_full) begin
          errors++;
          $display("FAIL o_valid t=%0t got=%b exp=%b", $time, bus.o_valid, m_full);
        end
        if (m_full && sb.size() > 0) begin
          checks++;
          if (bus.o_B !== sb[0].vec || bus.o_count !== sb[0].cnt) begin
            errors++;
            $display("FAIL vector t=%0t got=%h/%0d exp=%h/%0d", $time, bus.o_B, bus.o_count,
                     sb[0].vec, sb[0].cnt);
          end
`ifdef DEMUX_LANE_MASK_EN
          em = '0;
          for (int k = 0; k < 16; k++) if (k < int'(sb[0].cnt)) em[k] = 1'b1;
          checks++;
          if (bus.o_lane_mask !== em) begin
            errors++;
            $display("FAIL lane_mask t=%0t got=%h exp=%h", $time, bus.o_lane_mask, em);
          end
`endif
        end
        acc = bus.i_valid && m_ready;
        tk  = m_full && bus.i_ready;
        if (m_full) begin
          if (tk) begin
            if (sb.size() > 0) void'(sb.pop_front());
            m_full = 1'b0;
            if (acc) begin
              m_vec[15:0] = bus.i_data;
              m_cnt = 1;
            end
          end
        end else begin
          if (acc) begin
            m_vec[m_cnt*16 +: 16] = bus.i_data;
            m_cnt++;
          end
          if ((acc && m_cnt == 16) || (bus.i_flush && m_cnt > 0)) begin
            sb.push_back('{m_vec, 5'(m_cnt)});
            m_full = 1'b1;
            m_vec  = '0;
            m_cnt  = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  // Presents one word and holds it until the handshake completes; returns just after that edge.
  task automatic send_word(input logic [15:0] d, input logic fl);
    bit done = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_flush = fl;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = bus.o_ready;
      step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%h got=no_accept exp=accept", d);
    end
    bus.i_flush = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    if (bus.o_B !== '0) begin errors++; $display("FAIL reset_B got=%h exp=0", bus.o_B); end
    if (bus.o_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.o_count); end
    if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_stream();
    bus.i_ready = 1'b1;
    for (int k = 1; k <= 16; k++) send_word(16'(k), 1'b0);
    idle();
    checks += 4;
    if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", bus.o_valid); end
    if (bus.o_B[15:0] !== 16'h0001) begin errors++; $display("FAIL full_lane0 got=%h exp=0001", bus.o_B[15:0]); end
    if (bus.o_B[255:240] !== 16'h0010) begin errors++; $display("FAIL full_lane15 got=%h exp=0010", bus.o_B[255:240]); end
    if (bus.o_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", bus.o_count); end
    step();
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL full_taken got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_word(16'h2000 + 16'(k), 1'b0);
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h5555;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", c, bus.o_ready); end
      step();
    end
    bus.i_ready = 1'b1;
    step();
    checks += 2;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_taken got=%b exp=0", bus.o_valid); end
    if (bus.o_B !== 256'h5555) begin errors++; $display("FAIL bp_lane0 got=%h exp=5555", bus.o_B); end
    for (int k = 1; k < 16; k++) send_word(16'h6000 + 16'(k), 1'b0);
    idle();
    step();
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b1;
    send_word(16'hAAAA, 1'b0);
    send_word(16'hBBBB, 1'b0);
    send_word(16'hCCCC, 1'b0);
    idle();
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    checks += 4;
    if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got=%b exp=1", bus.o_valid); end
    if (bus.o_count !== 5'd3) begin errors++; $display("FAIL flush_count got=%0d exp=3", bus.o_count); end
    if (bus.o_B[255:48] !== '0) begin errors++; $display("FAIL flush_upper got=%h exp=0", bus.o_B[255:48]); end
    if (bus.o_B[47:0] !== 48'hCCCC_BBBB_AAAA) begin errors++; $display("FAIL flush_lanes got=%h exp=ccccbbbbaaaa", bus.o_B[47:0]); end
`ifdef DEMUX_LANE_MASK_EN
    checks++;
    if (bus.o_lane_mask !== 16'h0007) begin errors++; $display("FAIL flush_mask got=%h exp=0007", bus.o_lane_mask); end
`endif
    step();
  endtask

  task automatic test_flush_accept();
    bus.i_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_word(16'h4000 + 16'(k), 1'b0);
    send_word(16'h1234, 1'b1);
    idle();
    checks += 3;
    if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL flacc_valid got=%b exp=1", bus.o_valid); end
    if (bus.o_count !== 5'd6) begin errors++; $display("FAIL flacc_count got=%0d exp=6", bus.o_count); end
    if (bus.o_B[95:80] !== 16'h1234) begin errors++; $display("FAIL flacc_lane5 got=%h exp=1234", bus.o_B[95:80]); end
    step();
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL empty_flush got=%b exp=0", bus.o_valid); end
    step();
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL empty_flush2 got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b1;
    for (int k = 0; k < 7; k++) send_word(16'h3000 + 16'(k), 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.o_valid); end
    if (bus.o_B !== '0) begin errors++; $display("FAIL rmid_B got=%h exp=0", bus.o_B); end
    if (bus.o_count !== 5'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", bus.o_count); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 16; k++) send_word(16'h7000 + 16'(k), 1'b0);
    idle();
    checks += 3;
    if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL rmid_fresh_valid got=%b exp=1", bus.o_valid); end
    if (bus.o_B[15:0] !== 16'h7000) begin errors++; $display("FAIL rmid_lane0 got=%h exp=7000", bus.o_B[15:0]); end
    if (bus.o_B[255:240] !== 16'h700F) begin errors++; $display("FAIL rmid_lane15 got=%h exp=700f", bus.o_B[255:240]); end
    step();
  endtask

  task automatic test_single_lane();
    logic [15:0] q1[$];
    logic [15:0] e;
    bus1.i_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step();
      if (i > 0) begin
        e = q1.pop_front();
        checks += 3;
        if (bus1.o_valid !== 1'b1) begin errors++; $display("FAIL one_valid i=%0d got=%b exp=1", i, bus1.o_valid); end
        if (bus1.o_B !== e) begin errors++; $display("FAIL one_B i=%0d got=%h exp=%h", i, bus1.o_B, e); end
        if (bus1.o_count !== 5'd1) begin errors++; $display("FAIL one_count i=%0d got=%0d exp=1", i, bus1.o_count); end
      end
      if (i < 10) begin
        bus1.i_valid = 1'b1;
        bus1.i_data  = 16'h0100 + 16'(i * 7);
        q1.push_back(bus1.i_data);
      end else begin
        bus1.i_valid = 1'b0;
      end
    end
    step();
    checks++;
    if (bus1.o_valid !== 1'b0) begin errors++; $display("FAIL one_drain got=%b exp=0", bus1.o_valid); end
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    bus1.i_valid = 1'b0; bus1.i_data = '0; bus1.i_flush = 1'b0; bus1.i_ready = 1'b1;
    test_reset();
    test_full_stream();
    test_backpressure();
    test_flush();
    test_flush_accept();
    test_reset_mid();
    test_single_lane();
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
